// File: rtl/keypad_scan_pkg.sv
// Shared encodings for the keypad scanner: debounce states, per-frame scan results,
// and a small saturating adder used to count active keys (0, 1, >=2).
package keypad_scan_pkg;

  typedef enum logic [1:0] {
    DB_IDLE,
    DB_PRESS_CHK,
    DB_HELD,
    DB_REL_CHK
  } db_state_t;

  typedef enum logic [1:0] {
    FR_NONE,
    FR_KEY,
    FR_MULTI
  } frame_res_t;

  function automatic logic [1:0] sat2_add(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 3'd2) ? 2'd2 : s[1:0];
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Press/release debouncer, advancing only on frame ends; emits a one-cycle press event
// combinationally on the accepting frame end. No backpressure: the consumer decides drop/load.
module keypad_debounce
  import keypad_scan_pkg::*;
#(
  parameter int DEBOUNCE = 4,
  parameter int CODE_W   = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_frame_done,
  input  frame_res_t        i_frame_result,
  input  logic [CODE_W-1:0] i_frame_code,
  output logic              o_press_evt,
  output logic [CODE_W-1:0] o_press_code,
  output logic              o_key_down
);

  localparam int STAB_W = $clog2(DEBOUNCE + 1);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(DEBOUNCE);
  localparam logic [STAB_W-1:0] STAB_ONE = STAB_W'(1);

  db_state_t         r_state, w_state_nxt;
  logic [STAB_W-1:0] r_stab, w_stab_nxt, w_stab_inc;
  logic [CODE_W-1:0] r_cand, w_cand_nxt;

  assign w_stab_inc = (r_stab == STAB_MAX) ? r_stab : r_stab + STAB_ONE;

  always_comb begin
    w_state_nxt = r_state;
    w_stab_nxt  = r_stab;
    w_cand_nxt  = r_cand;
    o_press_evt = 1'b0;
    if (i_frame_done) begin
      unique case (r_state)
        DB_IDLE: if (i_frame_result == FR_KEY) begin
          w_cand_nxt  = i_frame_code;
          w_stab_nxt  = STAB_ONE;
          w_state_nxt = DB_PRESS_CHK;
        end
        DB_PRESS_CHK: begin
          if (i_frame_result == FR_KEY) begin
            if (i_frame_code == r_cand) begin
              w_stab_nxt = w_stab_inc;
            end else begin
              w_cand_nxt = i_frame_code;
              w_stab_nxt = STAB_ONE;
            end
          end else if (i_frame_result == FR_NONE) begin
            w_state_nxt = DB_IDLE;
          end
        end
        DB_HELD: if (i_frame_result == FR_NONE) begin
          w_stab_nxt  = STAB_ONE;
          w_state_nxt = DB_REL_CHK;
        end
        DB_REL_CHK: begin
          if (i_frame_result == FR_NONE) begin
            w_stab_nxt = w_stab_inc;
          end else if (i_frame_result == FR_KEY) begin
            w_state_nxt = DB_HELD;
          end
        end
        default: ;
      endcase
      // Checked after the count update so DEBOUNCE=1 accepts/releases on the first frame.
      if (w_state_nxt == DB_PRESS_CHK && w_stab_nxt == STAB_MAX) begin
        w_state_nxt = DB_HELD;
        o_press_evt = 1'b1;
      end else if (w_state_nxt == DB_REL_CHK && w_stab_nxt == STAB_MAX) begin
        w_state_nxt = DB_IDLE;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= DB_IDLE;
      r_stab  <= '0;
      r_cand  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_stab  <= w_stab_nxt;
      r_cand  <= w_cand_nxt;
    end
  end

  assign o_press_code = w_cand_nxt;
  assign o_key_down   = (r_state == DB_HELD) || (r_state == DB_REL_CHK);

endmodule

// File: rtl/keypad_scan.sv
// Matrix keypad scanner: one-cold row drive, synced column sampling, per-frame debounce; press
// reaches o_key_valid within (DEBOUNCE+1)*ROWS*SCAN_DIV+3 clk. Held code waits on ready; extra presses set overrun.
module keypad_scan
  import keypad_scan_pkg::*;
#(
  parameter int  ROWS     = 4,
  parameter int  COLS     = 4,
  parameter int  SCAN_DIV = 5000,
  parameter int  DEBOUNCE = 4,
  localparam int CODE_W   = $clog2(ROWS * COLS)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic [ROWS-1:0]   o_row_n,
  input  logic [COLS-1:0]   i_col_n,
  output logic [CODE_W-1:0] o_key_code,
  output logic              o_key_valid,
  input  logic              i_key_ready,
  output logic              o_key_down,
  output logic              o_overrun
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

  logic [COLS-1:0]   r_col_s1, r_col_s2;
  logic [DIV_W-1:0]  r_div;
  logic [ROW_W-1:0]  r_row;
  logic [1:0]        r_acc_cnt;
  logic [CODE_W-1:0] r_acc_code;
  logic [CODE_W-1:0] r_key_code;
  logic              r_key_valid, r_overrun;

  logic              w_slot_end, w_frame_end, w_take, w_press_evt;
  logic [1:0]        w_row_cnt, w_tot;
  logic [COL_W-1:0]  w_row_col;
  logic [CODE_W-1:0] w_cur_code, w_frame_code, w_press_code;
  frame_res_t        w_frame_result;

  assign w_slot_end  = (r_div == DIV_W'(SCAN_DIV - 1));
  assign w_frame_end = w_slot_end && (r_row == ROW_W'(ROWS - 1));
  assign o_row_n     = ~(ROWS'(1) << r_row);

  // Walk high to low so the lowest active column ends up as the row's first key.
  always_comb begin
    w_row_cnt = 2'd0;
    w_row_col = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (!r_col_s2[c]) begin
        w_row_cnt = sat2_add(w_row_cnt, 2'd1);
        w_row_col = COL_W'(c);
      end
    end
  end

  assign w_tot          = sat2_add(r_acc_cnt, w_row_cnt);
  assign w_cur_code     = CODE_W'(r_row) * CODE_W'(COLS) + CODE_W'(w_row_col);
  assign w_frame_code   = (r_acc_cnt == 2'd0) ? w_cur_code : r_acc_code;
  assign w_frame_result = (w_tot == 2'd0) ? FR_NONE : (w_tot == 2'd1) ? FR_KEY : FR_MULTI;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_col_s1   <= '1;
      r_col_s2   <= '1;
      r_div      <= '0;
      r_row      <= '0;
      r_acc_cnt  <= 2'd0;
      r_acc_code <= '0;
    end else begin
      r_col_s1 <= i_col_n;
      r_col_s2 <= r_col_s1;
      r_div    <= w_slot_end ? '0 : r_div + DIV_W'(1);
      if (w_slot_end) begin
        r_row <= (r_row == ROW_W'(ROWS - 1)) ? '0 : r_row + ROW_W'(1);
      end
      if (w_frame_end) begin
        r_acc_cnt  <= 2'd0;
        r_acc_code <= '0;
      end else if (w_slot_end) begin
        r_acc_cnt  <= w_tot;
        r_acc_code <= w_frame_code;
      end
    end
  end

  keypad_debounce #(
    .DEBOUNCE (DEBOUNCE),
    .CODE_W   (CODE_W)
  ) u_debounce (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_frame_done   (w_frame_end),
    .i_frame_result (w_frame_result),
    .i_frame_code   (w_frame_code),
    .o_press_evt    (w_press_evt),
    .o_press_code   (w_press_code),
    .o_key_down     (o_key_down)
  );

  assign w_take = r_key_valid && i_key_ready;

  // A press coinciding with a read reloads the slot and leaves overrun alone.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (w_press_evt) begin
      if (!r_key_valid || w_take) begin
        r_key_code  <= w_press_code;
        r_key_valid <= 1'b1;
      end else begin
        r_overrun <= 1'b1;
      end
    end else if (w_take) begin
      r_key_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end
  end

  assign o_key_code  = r_key_code;
  assign o_key_valid = r_key_valid;
  assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_keypad_scan.sv
// Frame-level reference model of the keypad scanner driven by directed and random key patterns.
// Patterns change only at frame starts, so each frame sees one stable key set.
module tb_keypad_scan;

  localparam int D = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [3:0]  key_code;
  logic        key_valid, key_ready = 1'b0, key_down, overrun;
  logic [15:0] pressed = 16'h0;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: debounced-held flag, candidate run length, release run length, handshake slot.
  int m_run = 0, m_rel = 0, m_cand = 0, m_code = 0;
  bit m_down = 0, m_valid = 0, m_over = 0;

  always #5 clk = ~clk;

  function automatic logic [3:0] cols_of(input logic [3:0] rn, input logic [15:0] p);
    logic [3:0] res;
    res = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!rn[r] && p[r*4+c]) res[c] = 1'b0;
    return res;
  endfunction

  assign col_n = cols_of(row_n, pressed);

  keypad_scan #(.ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(D)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .o_row_n     (row_n),
    .i_col_n     (col_n),
    .o_key_code  (key_code),
    .o_key_valid (key_valid),
    .i_key_ready (key_ready),
    .o_key_down  (key_down),
    .o_overrun   (overrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_valid"}, 32'(key_valid), 32'(m_valid));
    check({tag, "_code"}, 32'(key_code), 32'(m_code));
    check({tag, "_down"}, 32'(key_down), 32'(m_down));
    check({tag, "_overrun"}, 32'(overrun), 32'(m_over));
  endtask

  task automatic model_frame(input logic [15:0] pat, input bit ready_at_end);
    int  n, k;
    bit  evt, take;
    n   = $countones(pat);
    k   = 0;
    evt = 0;
    for (int i = 15; i >= 0; i--) if (pat[i]) k = i;
    if (n == 0) begin
      if (m_down) begin
        m_rel++;
        if (m_rel >= D) begin
          m_down = 0;
          m_run  = 0;
        end
      end else begin
        m_run = 0;
      end
    end else if (n == 1) begin
      if (!m_down) begin
        if (m_run > 0 && k == m_cand) m_run++;
        else begin
          m_cand = k;
          m_run  = 1;
        end
        if (m_run >= D) begin
          m_down = 1;
          m_rel  = 0;
          evt    = 1;
        end
      end else begin
        m_rel = 0;
      end
    end
    take = m_valid && ready_at_end;
    if (evt) begin
      if (!m_valid || take) begin
        m_valid = 1;
        m_code  = m_cand;
      end else begin
        m_over = 1;
      end
    end else if (take) begin
      m_valid = 0;
      m_over  = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_run = 0; m_rel = 0; m_cand = 0; m_code = 0;
    m_down = 0; m_valid = 0; m_over = 0;
    check("rst_row_n", 32'(row_n), 32'h0000000E);
    check_outputs("rst");
  endtask

  // rmode: 0 = no read, 1 = one-cycle read at frame start, 2 = read only on the frame-end edge.
  task automatic run_frame(input logic [15:0] pat, input int rmode);
    logic [3:0] exp_row;
    pressed = pat;
    if (rmode == 1) key_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 1 && rmode == 1) begin
        key_ready = 1'b0;
        if (m_valid) begin
          m_valid = 0;
          m_over  = 0;
        end
        check("read_valid", 32'(key_valid), 32'(m_valid));
        check("read_overrun", 32'(overrun), 32'(m_over));
      end
      if (k == 4 || k == 8 || k == 12) begin
        exp_row = 4'h1;
        exp_row = ~(exp_row << (k / 4));
        check("row_walk", 32'(row_n), 32'(exp_row));
      end
      if (k == 15 && rmode == 2) key_ready = 1'b1;
      if (k == 16) begin
        key_ready = 1'b0;
        model_frame(pat, rmode == 2);
        check("frame_row_n", 32'(row_n), 32'h0000000E);
        check_outputs("frame");
      end
    end
  endtask

  task automatic frames(input logic [15:0] pat, input int count, input int rmode);
    for (int i = 0; i < count; i++) run_frame(pat, rmode);
  endtask

  initial begin
    logic [15:0] pat, prev;
    int a, b, sel;

    do_reset();

    // Single press of key 6 (row 1, col 2), then read it.
    frames(16'h0040, 3, 0);
    check("t2_code", 32'(key_code), 32'd6);
    check("t2_valid", 32'(key_valid), 32'd1);
    run_frame(16'h0040, 1);

    // Release, bounce on alternate frames, then settle.
    frames(16'h0000, 3, 0);
    for (int i = 0; i < 8; i++) run_frame((i % 2 == 0) ? 16'h0040 : 16'h0000, 0);
    check("t3_bounce_valid", 32'(key_valid), 32'd0);
    frames(16'h0040, 3, 0);

    // Unread code 6, release, press 9: dropped, overrun set; then read.
    frames(16'h0000, 3, 0);
    frames(16'h0200, 3, 0);
    check("t4_code_kept", 32'(key_code), 32'd6);
    check("t4_overrun", 32'(overrun), 32'd1);
    run_frame(16'h0200, 1);

    // Two keys together from idle, then key 3 added while 6 is held.
    frames(16'h0000, 3, 0);
    frames(16'h0021, 6, 0);
    check("t5_ghost_down", 32'(key_down), 32'd0);
    frames(16'h0040, 3, 1);
    frames(16'h0048, 3, 0);

    // Press collides with a read on the accepting edge: reload, overrun untouched.
    frames(16'h0000, 3, 0);
    run_frame(16'h0400, 0);
    run_frame(16'h0400, 2);
    check("collide_code", 32'(key_code), 32'd10);

    // Resets mid-debounce and while a code is pending.
    frames(16'h0000, 3, 1);
    run_frame(16'h0040, 0);
    do_reset();
    frames(16'h0040, 2, 0);
    do_reset();
    frames(16'h0040, 2, 0);
    check("t6_redetect", 32'(key_valid), 32'd1);

    // Random key patterns with random read timing.
    prev = 16'h0;
    for (int f = 0; f < 120; f++) begin
      pat = prev;
      if ($urandom_range(0, 9) < 4) begin
        sel = $urandom_range(0, 9);
        if (sel < 3) pat = 16'h0;
        else if (sel < 8) begin
          pat = 16'h0;
          pat[$urandom_range(0, 15)] = 1'b1;
        end else begin
          a = $urandom_range(0, 15);
          b = (a + 1 + $urandom_range(0, 14)) % 16;
          pat = 16'h0;
          pat[a] = 1'b1;
          pat[b] = 1'b1;
        end
      end
      if ($urandom_range(0, 49) == 0) do_reset();
      sel = $urandom_range(0, 3);
      run_frame(pat, (sel == 3) ? 0 : sel);
      prev = pat;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
